// File: rtl/window_gen.sv
// Sliding K x K window generator: raster pixels in, one window per accepted pixel
// once the bottom-right corner is at least K-1 rows and K-1 columns into the frame.
module window_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IN_CHANNEL  = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    pixel_valid,
  input  logic [IN_CHANNEL*DATA_WIDTH-1:0]                        pixel_in,
  output logic                                                    window_valid,
  output logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic [$clog2(IMG_HEIGHT)-1:0]                           out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]                            out_col,
  output logic                                                    frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int PW = IN_CHANNEL * DATA_WIDTH;
  localparam int OW = IN_CHANNEL * K * K * DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_last, row_last, emit;
  logic          window_valid_q, frame_done_q;
  logic [RW-1:0] out_row_q;
  logic [CW-1:0] out_col_q;
  logic [OW-1:0] window_out_q, window_flat_d;

  // lb_q[0] holds the row just above the current one, lb_q[K-2] the oldest.
  logic [PW-1:0] lb_q  [K-1][IMG_WIDTH];
  logic [PW-1:0] win_q [K][K];
  logic [PW-1:0] win_d [K][K];
  logic [PW-1:0] colv  [K];

  always_comb begin
    col_last = (col_q == CW'(IMG_WIDTH - 1));
    row_last = (row_q == RW'(IMG_HEIGHT - 1));
    col_d    = col_last ? '0 : col_q + 1'b1;
    row_d    = row_q;
    if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
    emit = pixel_valid && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

    colv[K-1] = pixel_in;
    for (int j = 0; j < K - 1; j++) colv[K-2-j] = lb_q[j][col_q];

    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = colv[r];
    end

    window_flat_d = '0;
    for (int ch = 0; ch < IN_CHANNEL; ch++)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          window_flat_d[(ch*K*K + r*K + c)*DATA_WIDTH +: DATA_WIDTH] =
            win_d[r][c][ch*DATA_WIDTH +: DATA_WIDTH];
  end

  // Control and output registers: cleared by reset, stepped only on accepted pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q          <= '0;
      row_q          <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      window_out_q   <= '0;
    end else begin
      window_valid_q <= emit;
      frame_done_q   <= emit && row_last && col_last;
      if (pixel_valid) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (emit) begin
        window_out_q <= window_flat_d;
        out_row_q    <= row_q;
        out_col_q    <= col_q;
      end
    end
  end

  // Line buffers and shift window carry pixel data only; rows below K-1 and
  // columns below K-1 never reach the output, so no clearing is needed.
  always_ff @(posedge clk) begin
    if (pixel_valid) begin
      win_q <= win_d;
      lb_q[0][col_q] <= pixel_in;
      for (int j = 1; j < K - 1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
    end
  end

  assign window_valid = window_valid_q;
  assign frame_done   = frame_done_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign window_out   = window_out_q;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen: image-array reference model, ramp and random frames,
// random valid gaps, back-to-back frames and reset in mid-frame.
module tb_window_gen;

  localparam int D  = 8;
  localparam int K  = 3;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int PW = CH * D;
  localparam int WW = CH * K * K * D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pixel_valid;
  logic [PW-1:0] pixel_in;
  logic          window_valid;
  logic [WW-1:0] window_out;
  logic [2:0]    out_row;
  logic [2:0]    out_col;
  logic          frame_done;

  window_gen #(.DATA_WIDTH(D), .KERNEL_SIZE(K), .IN_CHANNEL(CH),
               .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
    .window_valid(window_valid), .window_out(window_out),
    .out_row(out_row), .out_col(out_col), .frame_done(frame_done));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the image as received, raster position, expected outputs.
  logic [PW-1:0] img [H][W];
  int            mr, mc;
  logic          e_vld, e_done;
  logic [WW-1:0] e_win;
  int            e_row, e_col;

  task automatic model_reset();
    mr = 0; mc = 0; e_vld = 0; e_done = 0; e_win = '0; e_row = 0; e_col = 0;
  endtask

  task automatic model_accept(input logic v, input logic [PW-1:0] px);
    logic [PW-1:0] p;
    e_vld = 0;
    e_done = 0;
    if (v) begin
      img[mr][mc] = px;
      if (mr >= K - 1 && mc >= K - 1) begin
        e_vld = 1;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) begin
            p = img[mr-K+1+r][mc-K+1+c];
            for (int ch = 0; ch < CH; ch++)
              e_win[(ch*K*K + r*K + c)*D +: D] = p[ch*D +: D];
          end
        e_row  = mr;
        e_col  = mc;
        e_done = (mr == H - 1) && (mc == W - 1);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr + 1) % H;
      end
    end
  endtask

  function automatic logic [PW-1:0] ramp(input int off, input int r, input int c);
    logic [PW-1:0] px;
    for (int ch = 0; ch < CH; ch++) px[ch*D +: D] = D'(r*8 + c + ch*64 + off);
    return px;
  endfunction

  task automatic step(input logic v, input logic [PW-1:0] px);
    @(negedge clk);
    pixel_valid = v;
    pixel_in    = px;
    @(posedge clk);
    #1;
    model_accept(v, px);
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pixel_valid = (i == 0);
      pixel_in    = PW'($urandom());
      @(posedge clk);
      #1;
      total++;
      if ({window_valid, frame_done, out_row, out_col, window_out} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d got v=%0b d=%0b r=%0d c=%0d w=%h want all zero",
                 i, window_valid, frame_done, out_row, out_col, window_out);
      end
    end
    @(negedge clk);
    rst_n = 1;
    pixel_valid = 0;
    model_reset();
  endtask

  task automatic test_ramp();
    int n = 0, first = -1, lr = -1, lc = -1;
    logic ld = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, ramp(0, i / W, i % W));
      total++;
      if ({window_valid, frame_done, out_row, out_col, window_out} !==
          {e_vld, e_done, 3'(e_row), 3'(e_col), e_win}) begin
        bad++;
        $display("FAIL ramp_window i=%0d got v=%0b d=%0b r=%0d c=%0d w=%h want v=%0b d=%0b r=%0d c=%0d w=%h",
                 i, window_valid, frame_done, out_row, out_col, window_out,
                 e_vld, e_done, e_row, e_col, e_win);
      end
      if (window_valid) begin
        if (first < 0) begin
          first = i;
          total++;
          if (window_out[0 +: 8] !== 8'd0 || window_out[32 +: 8] !== 8'd9 ||
              window_out[64 +: 8] !== 8'd18 || window_out[208 +: 8] !== 8'd146) begin
            bad++;
            $display("FAIL ramp_first_values got i0=%0d i4=%0d i8=%0d ch2i8=%0d want 0 9 18 146",
                     window_out[0 +: 8], window_out[32 +: 8], window_out[64 +: 8], window_out[208 +: 8]);
          end
        end
        n++;
        lr = out_row; lc = out_col; ld = frame_done;
      end
    end
    total++;
    if (first !== 18) begin
      bad++;
      $display("FAIL ramp_first_latency got pixel=%0d want 18", first);
    end
    total++;
    if (n !== 36 || lr !== 7 || lc !== 7 || ld !== 1'b1) begin
      bad++;
      $display("FAIL ramp_count_last got n=%0d r=%0d c=%0d done=%0b want 36 7 7 1", n, lr, lc, ld);
    end
  endtask

  task automatic test_gaps(input logic rand_data);
    int acc = 0, n = 0;
    logic v;
    logic [PW-1:0] px;
    for (int cyc = 0; cyc < 2000 && acc < W * H; cyc++) begin
      v  = ($urandom_range(0, 99) >= 30);
      px = rand_data ? PW'($urandom()) : (v ? ramp(0, acc / W, acc % W) : PW'($urandom()));
      step(v, px);
      if (v) acc++;
      if (window_valid) n++;
      total++;
      if ({window_valid, frame_done, out_row, out_col, window_out} !==
          {e_vld, e_done, 3'(e_row), 3'(e_col), e_win}) begin
        bad++;
        $display("FAIL gaps_window cyc=%0d v_in=%0b got v=%0b d=%0b r=%0d c=%0d w=%h want v=%0b d=%0b r=%0d c=%0d w=%h",
                 cyc, v, window_valid, frame_done, out_row, out_col, window_out,
                 e_vld, e_done, e_row, e_col, e_win);
      end
    end
    total++;
    if (acc !== W * H || n !== 36) begin
      bad++;
      $display("FAIL gaps_count got pixels=%0d windows=%0d want 64 36", acc, n);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic seen2 = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < W * H; i++) begin
        step(1'b1, ramp(f, i / W, i % W));
        total++;
        if ({window_valid, frame_done, out_row, out_col, window_out} !==
            {e_vld, e_done, 3'(e_row), 3'(e_col), e_win}) begin
          bad++;
          $display("FAIL b2b_window f=%0d i=%0d got v=%0b d=%0b r=%0d c=%0d w=%h want v=%0b d=%0b r=%0d c=%0d w=%h",
                   f, i, window_valid, frame_done, out_row, out_col, window_out,
                   e_vld, e_done, e_row, e_col, e_win);
        end
        if (window_valid) begin
          n++;
          total++;
          if (out_row < 2 || out_col < 2) begin
            bad++;
            $display("FAIL b2b_edge got r=%0d c=%0d want both >= 2", out_row, out_col);
          end
          if (f == 1 && !seen2) begin
            seen2 = 1;
            total++;
            if (window_out[7:0] !== 8'd1 || out_row !== 3'd2 || out_col !== 3'd2) begin
              bad++;
              $display("FAIL b2b_frame2_first got i0=%0d r=%0d c=%0d want 1 2 2",
                       window_out[7:0], out_row, out_col);
            end
          end
        end
      end
    total++;
    if (n !== 72) begin
      bad++;
      $display("FAIL b2b_count got %0d want 72", n);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    for (int i = 0; i < 20; i++) step(1'b1, PW'($urandom()));
    test_reset();
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, ramp(0, i / W, i % W));
      total++;
      if ({window_valid, frame_done, out_row, out_col, window_out} !==
          {e_vld, e_done, 3'(e_row), 3'(e_col), e_win}) begin
        bad++;
        $display("FAIL midreset_window i=%0d got v=%0b d=%0b r=%0d c=%0d w=%h want v=%0b d=%0b r=%0d c=%0d w=%h",
                 i, window_valid, frame_done, out_row, out_col, window_out,
                 e_vld, e_done, e_row, e_col, e_win);
      end
      if (window_valid) n++;
    end
    total++;
    if (n !== 36) begin
      bad++;
      $display("FAIL midreset_count got %0d want 36", n);
    end
  endtask

  initial begin
    rst_n       = 0;
    pixel_valid = 0;
    pixel_in    = '0;
    model_reset();
    test_reset();
    test_ramp();
    test_gaps(1'b0);
    test_gaps(1'b1);
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 8: unsigned pixel width per channel.
- REQ-002 SHALL have parameter KERNEL_SIZE, default 3: window edge K.
- REQ-003 SHALL have parameter IN_CHANNEL, default 3: channel count.
- REQ-004 SHALL have parameter IMG_WIDTH, default 8: pixels per row W, with W >= K.
- REQ-005 SHALL have parameter IMG_HEIGHT, default 8: rows per frame H, with H >= K.
- REQ-006 SHALL have port clk, input, width 1: single clock, all logic on the rising edge.
- REQ-007 SHALL have port rst_n, input, width 1: reset, synchronous and active-low.
- REQ-008 SHALL have port pixel_valid, input, width 1: pixel_in is accepted in any cycle where this is high.
- REQ-009 SHALL have port pixel_in, input, width IN_CHANNEL*DATA_WIDTH: channel ch in bits [ch*DATA_WIDTH +: DATA_WIDTH].
- REQ-010 SHALL have port window_valid, output, width 1: window_out holds a new window.
- REQ-011 SHALL have port window_out, output, width IN_CHANNEL*K*K*DATA_WIDTH: element (ch,i) in bits [(ch*K*K+i)*DATA_WIDTH +: DATA_WIDTH], with i = r*K+c.
- REQ-012 SHALL have port out_row, output, width clog2(IMG_HEIGHT): image row of the window's bottom-right pixel.
- REQ-013 SHALL have port out_col, output, width clog2(IMG_WIDTH): image column of the window's bottom-right pixel.
- REQ-014 SHALL have port frame_done, output, width 1: pulses with the last window of the frame.

Function
- REQ-015 SHALL take input in raster order: column counter 0..W-1, then row counter 0..H-1, advancing only on accepted pixels.
- REQ-016 SHALL keep K-1 line buffers of depth W per channel, plus a K x K shift window per channel.
- REQ-017 When a pixel is accepted at (row R, col C) with R >= K-1 and C >= K-1, SHALL register the window in the next cycle and assert window_valid for exactly 1 cycle (latency 1).
- REQ-018 Window element (r,c) SHALL equal the image pixel at (R-K+1+r, C-K+1+c); r=0 is the oldest row, c=0 the leftmost column.
- REQ-019 SHALL produce no window for accepted pixels with R < K-1 or C < K-1, so no window spans a row wrap.
- REQ-020 SHALL set out_row/out_col to R/C, registered together with window_out.
- REQ-021 Exactly (H-K+1)*(W-K+1) windows per frame (36 at defaults).
- REQ-022 On acceptance of pixel (H-1, W-1), both counters SHALL wrap to 0 and frame_done SHALL pulse in the same cycle as that pixel's window_valid.
- REQ-023 The next frame SHALL follow with no gap cycles required, and no window SHALL mix pixels of two frames.
- REQ-024 With pixel_valid low: no counter, buffer or window state change; window_valid and frame_done low next cycle; window_out, out_row and out_col hold.
- REQ-025 There is no backpressure: the consumer SHALL sample window_out while window_valid is high.
- REQ-026 Pixel data SHALL be passed through unmodified and unsigned; no arithmetic on data.

Reset
- REQ-027 While rst_n is low at a clock edge: counters, window_valid, frame_done, out_row, out_col and window_out SHALL all be 0.
- REQ-028 Line buffer contents need not be cleared.
- REQ-029 Reset mid-frame SHALL abandon the partial frame; the first pixel accepted after reset is (0,0) of a new frame.

Verification
- REQ-030 Reset: rst_n low 2 cycles with pixel_valid toggling -> all outputs 0, no window_valid.
- REQ-031 Continuous 8x8 ramp, ch value = (R*8+C)+ch*64 mod 256 -> first window_valid 1 cycle after pixel (2,2) is accepted. That window reads ch0 i0=0, i4=9, i8=18, and ch2 i8=146. Total 36 pulses; last at out_row=7, out_col=7, with frame_done high.
- REQ-032 Same frame with random pixel_valid gaps (~30%) -> window contents and sequence identical to REQ-031; no valid pulses during gaps; outputs held.
- REQ-033 Two back-to-back frames, frame 2 = frame 1 + 1 -> 72 windows; frame 2's first window at (2,2) has ch0 i0=1; no window at C<2 or R<2.
- REQ-034 Reset after 20 pixels of a frame, then a full frame -> exactly 36 windows, matching REQ-031 values.
